// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op and state encodings,
// iteration count, and small op-decode helpers.
package mdu_defs;

  localparam int MDU_ITER = 32;

  localparam logic [1:0] MDU_MULT  = 2'b00;
  localparam logic [1:0] MDU_MULTU = 2'b01;
  localparam logic [1:0] MDU_DIV   = 2'b10;
  localparam logic [1:0] MDU_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } mdu_state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Controller <-> MDU bundle: launch/op/operands and mthi/mtlo writes in,
// busy/done status and the HI/LO registers out.
interface mdu_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, mthi, mtlo,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, mthi, mtlo,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift next dividend bit into the partial
// remainder, trial-subtract the divisor, keep the result if non-negative.
// Ports: rem_i/q_i/div_i in; rem_o, q_o (remaining dividend bits), qbit_o out.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-2:0] q_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shift;
  logic [WIDTH:0] diff;

  assign shift  = {rem_i, q_i[WIDTH-1]};
  assign diff   = shift - {1'b0, div_i};
  assign qbit_o = (shift >= {1'b0, div_i});

  // Remainder is always below the divisor, so it fits in WIDTH bits.
  assign rem_o = WIDTH'(qbit_o ? diff : shift);

  // Dividend bits still to be consumed move up; the caller
  // appends qbit_o at the bottom.
  assign q_o = q_i[WIDTH-2:0];

endmodule

// File: rtl/mul_div_unit.sv
// Iterative mult/multu/div/divu unit with HI/LO and mthi/mtlo; 33-edge latency.
// Ports: clk, reset (async, active-high), bus (mdu_if.slave). Option: MDU_EARLY_TERM_EN.
module mul_div_unit
  import mdu_defs::*;
#(
  parameter int WIDTH = MDU_ITER
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int W2 = 2 * WIDTH;

  mdu_state_e state_q, state_d;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;
  logic             sa_q, sa_d;
  logic             dz_q, dz_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [W2-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic             sgn_op;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;

  logic [W2-1:0]    prod_sum;
  logic [WIDTH-1:0] mplier_sh;
  logic             early;

  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-2:0] step_q;
  logic             step_qbit;

  logic [W2-1:0]    mul_res;
  logic [WIDTH-1:0] quo, rem;
  logic [WIDTH-1:0] div_lo, div_hi;

  // Operand magnitudes for launch.
  assign sgn_op = op_is_signed(bus.op);
  assign a_neg  = sgn_op & bus.a[WIDTH-1];
  assign b_neg  = sgn_op & bus.b[WIDTH-1];
  assign a_abs  = a_neg ? -bus.a : bus.a;
  assign b_abs  = b_neg ? -bus.b : bus.b;

  // Shift-add multiply step.
  assign prod_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mplier_sh = mplier_q >> 1;

`ifdef MDU_EARLY_TERM_EN
  // Remaining multiplier bits all zero: nothing left to add.
  assign early = ~is_div_q & (mplier_sh == '0);
`else
  assign early = 1'b0;
`endif

  // Divide keeps {remainder, dividend/quotient} in acc and the
  // divisor in the low half of mcand.
  mdu_div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i  (acc_q[W2-1:WIDTH]),
    .q_i    (acc_q[WIDTH-1:0]),
    .div_i  (mcand_q[WIDTH-1:0]),
    .rem_o  (step_rem),
    .q_o    (step_q),
    .qbit_o (step_qbit)
  );

  // Sign correction.
  assign mul_res = neg_q ? -acc_q : acc_q;
  assign quo     = acc_q[WIDTH-1:0];
  assign rem     = acc_q[W2-1:WIDTH];
  // Divide by zero leaves quotient all-ones; remainder holds |a|,
  // so giving it the dividend's sign restores a.
  assign div_lo  = (neg_q & ~dz_q) ? -quo : quo;
  assign div_hi  = sa_q ? -rem : rem;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sa_d     = sa_q;
    dz_d     = dz_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          is_div_d = op_is_div(bus.op);
          neg_d    = a_neg ^ b_neg;
          sa_d     = a_neg;
          dz_d     = (bus.b == '0);
          cnt_d    = CW'(WIDTH - 1);
          state_d  = S_CALC;
          if (op_is_div(bus.op)) begin
            acc_d    = {{WIDTH{1'b0}}, a_abs};
            mcand_d  = {{WIDTH{1'b0}}, b_abs};
            mplier_d = '0;
          end else begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_abs};
            mplier_d = b_abs;
          end
        end else begin
          if (bus.mthi) hi_d = bus.a;
          if (bus.mtlo) lo_d = bus.a;
        end
      end

      S_CALC: begin
        if (is_div_q) begin
          acc_d = {step_rem, step_q, step_qbit};
        end else begin
          acc_d    = prod_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_sh;
        end
        if ((cnt_q == '0) || early) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          hi_d = div_hi;
          lo_d = div_lo;
        end else begin
          hi_d = mul_res[W2-1:WIDTH];
          lo_d = mul_res[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sa_q     <= 1'b0;
      dz_q     <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sa_q     <= sa_d;
      dz_q     <= dz_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: results, latency, busy/done timing,
// mthi/mtlo gating and async reset mid-operation.
module tb_mul_div_unit;

  logic clk;
  logic reset;

  mdu_if #(.WIDTH(32)) bus ();

  mul_div_unit #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed status {busy, done, hi, lo}.
  function automatic logic [65:0] st(input logic bsy, input logic dn,
                                     input logic [31:0] h, input logic [31:0] l);
    return {bsy, dn, h, l};
  endfunction

  function automatic logic [65:0] now();
    return {bus.busy, bus.done, bus.hi, bus.lo};
  endfunction

  function automatic int lat_of(input logic [1:0] op, input logic [31:0] b);
`ifdef MDU_EARLY_TERM_EN
    logic [31:0] m;
    int r;
    if (op[1]) return 33;
    m = (op == 2'b00 && b[31]) ? -b : b;
    r = 2;
    for (int i = 0; i < 32; i++) if (m[i]) r = i + 2;
    return r;
`else
    return 33;
`endif
  endfunction

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    lat = lat_of(op, b);
    bus.op = op;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_e0"}, now(), st(1'b1, 1'b0, m_hi, m_lo));
    for (int k = 1; k < lat; k++) begin
      tick();
      check({tag, "_calc"}, now(), st(1'b1, 1'b0, m_hi, m_lo));
    end
    tick();
    check({tag, "_res"}, now(), st(1'b0, 1'b1, ehi, elo));
    m_hi = ehi;
    m_lo = elo;
    tick();
    check({tag, "_idle"}, now(), st(1'b0, 1'b0, m_hi, m_lo));
  endtask

  initial begin
    int lat, pulse, dn;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.a = '0;
    bus.b = '0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    tick();
    tick();
    check("reset", now(), st(1'b0, 1'b0, 32'h0, 32'h0));
    reset = 1'b0;
    tick();
    check("post_reset", now(), st(1'b0, 1'b0, 32'h0, 32'h0));

    run_op("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7dm2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_dz", 2'b11, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF);
    run_op("div_dz_neg", 2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("multu_b0", 2'b01, 32'd9, 32'd0, 32'h0, 32'h0);
    run_op("multu_5x3", 2'b01, 32'd5, 32'd3, 32'h0, 32'd15);

    // mthi and mtlo together in IDLE.
    bus.a = 32'h0000_00A5;
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    tick();
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    m_hi = 32'hA5;
    m_lo = 32'hA5;
    check("mthi_mtlo", now(), st(1'b0, 1'b0, m_hi, m_lo));

    // mthi alone.
    bus.a = 32'h0000_1234;
    bus.mthi = 1'b1;
    tick();
    bus.mthi = 1'b0;
    m_hi = 32'h1234;
    check("mthi", now(), st(1'b0, 1'b0, m_hi, m_lo));

    // multu 3*5 with mthi/mtlo alongside start (dropped) and a
    // mtlo pulse while calculating (ignored).
    lat = lat_of(2'b01, 32'd5);
    pulse = (lat > 11) ? 10 : lat - 1;
    bus.op = 2'b01;
    bus.a = 32'd3;
    bus.b = 32'd5;
    bus.start = 1'b1;
    bus.mthi = 1'b1;
    bus.mtlo = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.mthi = 1'b0;
    bus.mtlo = 1'b0;
    check("start_wins", now(), st(1'b1, 1'b0, 32'h1234, m_lo));
    for (int k = 1; k < lat; k++) begin
      if (k == pulse) begin
        bus.a = 32'hDEAD_BEEF;
        bus.mtlo = 1'b1;
        bus.mthi = 1'b1;
        bus.start = 1'b1;
      end
      tick();
      bus.mtlo = 1'b0;
      bus.mthi = 1'b0;
      bus.start = 1'b0;
      if (k == pulse || k == lat - 1)
        check("hold_calc", now(), st(1'b1, 1'b0, 32'h1234, m_lo));
    end
    tick();
    check("mtlo_busy_res", now(), st(1'b0, 1'b1, 32'h0, 32'd15));
    m_hi = 32'h0;
    m_lo = 32'd15;
    tick();
    check("no_queued_op", now(), st(1'b0, 1'b0, m_hi, m_lo));

    // Async reset in the middle of a second op.
    bus.op = 2'b11;
    bus.a = 32'd100;
    bus.b = 32'd7;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    check("pre_reset_busy", now(), st(1'b1, 1'b0, m_hi, m_lo));
    reset = 1'b1;
    #1;
    check("async_reset", now(), st(1'b0, 1'b0, 32'h0, 32'h0));
    m_hi = '0;
    m_lo = '0;
    tick();
    #2;
    reset = 1'b0;
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done || bus.busy) dn++;
    end
    n_cmp++;
    assert (dn == 0) else begin
      n_err++;
      $error("FAIL no_done_after_reset: observed %0d expected 0", dn);
    end
    check("reset_idle", now(), st(1'b0, 1'b0, 32'h0, 32'h0));

    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath. Sits beside the ALU.
- Consumes the regfile rs/rt read values (rd1/rd2) and holds results in internal HI/LO registers.
- mfhi/mflo read HI/LO through the writeback mux.
- Handles mult, multu, div, divu, mthi and mtlo. Raises busy so the controller can stall mfhi/mflo and new MDU ops.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH.

Ports:
- clk  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- start  input  1  launch op; sampled only in IDLE
- op  input  2  00 mult, 01 multu, 10 div, 11 divu
- a  input  WIDTH  rs value (dividend / multiplicand)
- b  input  WIDTH  rt value (divisor / multiplier)
- mthi  input  1  write a into HI
- mtlo  input  1  write a into LO
- busy  output  1  high while an op is in flight
- done  output  1  one-cycle pulse after HI/LO update
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (any time, including mid-operation):
  - state=IDLE; hi=lo=0; done=0; busy=0.
  - The in-flight op is discarded.
- States: IDLE, CALC, FIX.
  - busy = (state != IDLE), registered-state decode.
- IDLE, start=1 at edge E0:
  - Latch op, sign flags and operand magnitudes (two's-complement abs for signed ops).
  - Iteration counter = WIDTH-1; go to CALC.
  - mthi/mtlo in the same cycle as start are dropped; start wins.
- IDLE, start=0: mthi/mtlo load a into HI/LO at the edge; both may be asserted together.
- CALC, multiply (one step per edge, E1..E32):
  - If mplier[0]: acc64 += mcand64.
  - Then mcand64 <<= 1 and mplier >>= 1.
- CALC, divide (restoring, one quotient bit per edge):
  - rem = {rem, q_msb}; trial = rem - divisor.
  - If trial >= 0: rem = trial, qbit = 1; else qbit = 0.
- Counter reaching 0 at edge E32 moves the state to FIX.
- FIX, edge E33: sign correction, then write HI/LO.
  - Multiply: product negated if sign(a)!=sign(b) (signed op only); hi=prod[63:32], lo=prod[31:0].
  - Divide: lo=quotient, negated if signs differ; hi=remainder, taking the sign of the dividend.
- After E33: state=IDLE and done=1 for exactly one cycle. Latency from start edge to results is 33 edges.
- Divide by zero: runs full latency; hi=a (unmodified), lo={WIDTH{1}}; no sign fix.
- Divide 0x80000000 / -1 (signed): lo=0x80000000, hi=0, with no special casing.
- start, mthi and mtlo while busy are ignored. The controller must stall; the unit does not queue them.
- hi/lo change only at the FIX edge, on mthi/mtlo, or on reset. They are stable and readable during CALC, holding their old values.

Optional Feature:
- MDU_EARLY_TERM_EN defined:
  - Multiply ops leave CALC as soon as mplier==0 after a step.
  - Latency = (index of highest set bit of |b|) + 2 edges; b==0 gives 2 edges (E1 step, E2 FIX).
  - Divide is unaffected.
- Undefined: every op takes the fixed 33-edge latency.

Decomposition:
- Shared package/header mdu_defs:
  - Op encodings MDU_MULT=2'b00, MDU_MULTU=2'b01, MDU_DIV=2'b10, MDU_DIVU=2'b11.
  - State encodings S_IDLE/S_CALC/S_FIX.
  - MDU_ITER=32.
- One sub-module, mdu_div_step: combinational restoring-division step taking rem_in, q_in and divisor, producing rem_out, q_out and qbit. Instantiated once, used each CALC cycle.

Test Plan:
- mult a=0xFFFFFFFD (-3), b=7 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFEB; done one cycle; busy high E0..E33.
- multu a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- div a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu a=100, b=0 -> hi=0x00000064, lo=0xFFFFFFFF at full latency.
- mthi a=0x1234 in IDLE, then start multu 3*5 with mtlo pulsed at edge 10 of CALC -> hi reads 0x1234 during CALC; mtlo ignored; final hi=0, lo=15. Assert reset at edge 10 of a second op -> hi=lo=0, busy=0 immediately, no done pulse.
- With MDU_EARLY_TERM_EN: multu 5*3 -> results hi=0, lo=15 at E3, done after E3. Same stimulus without the macro -> results at E33.
